// File: rtl/operand_entry_pkg.sv
// Shared encodings for operand entry and the comparison block it feeds.
// Latency: n/a (types and constants only); backpressure: n/a.
package operand_entry_pkg;

    localparam int VAL_W = 4;
    localparam int OP_W  = 2;

    typedef enum logic [1:0] {
        S_X    = 2'b00,
        S_Y    = 2'b01,
        S_OP   = 2'b10,
        S_SHOW = 2'b11
    } state_e;

    typedef enum logic [OP_W-1:0] {
        OP_EQ  = 2'b00,
        OP_GT  = 2'b01,
        OP_LT  = 2'b10,
        OP_MAX = 2'b11
    } op_e;

    typedef struct packed {
        logic [VAL_W-1:0] x;
        logic [VAL_W-1:0] y;
        op_e              operation;
    } operand_set_t;

    localparam operand_set_t SET_CLEAR = '0;

    // The operation code rides on the low switch bits.
    function automatic op_e op_from_sw(input logic [VAL_W-1:0] sw);
        return op_e'(sw[OP_W-1:0]);
    endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Board-side keys/switches in, captured operand set and status out.
// Latency: n/a (wiring only); backpressure: none, outputs are level-held.
interface operand_entry_if;
    import operand_entry_pkg::*;

    logic [VAL_W-1:0] sw;
    logic             enter_n;
    logic             cancel_n;
    logic [VAL_W-1:0] x;
    logic [VAL_W-1:0] y;
    logic [OP_W-1:0]  operation;
    logic             valid;
    logic             new_set;
    logic [1:0]       stage;

    modport master (
        output sw, enter_n, cancel_n,
        input  x, y, operation, valid, new_set, stage
    );

    modport slave (
        input  sw, enter_n, cancel_n,
        output x, y, operation, valid, new_set, stage
    );

endinterface

// File: rtl/operand_entry_key_debounce.sv
// Synchronizes and debounces one active-low key, emitting a one-cycle press pulse.
// Latency: 2 + DEBOUNCE_CYCLES cycles from a held edge; backpressure: none.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        meta_d   = key_n;
        sync_d   = meta_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_q;
            cnt_d    = '0;
            // Only the released->pressed transition is an event.
            press_d  = stable_q & ~sync_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b1;
            sync_q   <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_entry.sv
// Sequences x, y, operation capture from debounced enter/cancel keys.
// Latency: outputs update one cycle after a press pulse; backpressure: none.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    operand_entry_if.slave  bus
);

    logic enter_evt;
    logic cancel_evt;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.enter_n),
        .press (enter_evt)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_cancel (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.cancel_n),
        .press (cancel_evt)
    );

    state_e       state_q, state_d;
    operand_set_t set_q, set_d;
    logic         valid_q, valid_d;
    logic         new_set_q, new_set_d;

    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        valid_d   = valid_q;
        new_set_d = 1'b0;
        // Cancel outranks a coincident enter.
        if (cancel_evt) begin
            state_d = S_X;
            set_d   = SET_CLEAR;
            valid_d = 1'b0;
        end else if (enter_evt) begin
            unique case (state_q)
                S_X: begin
                    set_d.x = bus.sw;
                    state_d = S_Y;
                end
                S_Y: begin
                    set_d.y = bus.sw;
                    state_d = S_OP;
                end
                S_OP: begin
                    set_d.operation = op_from_sw(bus.sw);
                    valid_d         = 1'b1;
                    new_set_d       = 1'b1;
                    state_d         = S_SHOW;
                end
                S_SHOW: begin
                    valid_d = 1'b0;
                    state_d = S_X;
                end
                default: state_d = S_X;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_X;
            set_q     <= SET_CLEAR;
            valid_q   <= 1'b0;
            new_set_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            valid_q   <= valid_d;
            new_set_q <= new_set_d;
        end
    end

    assign bus.x         = set_q.x;
    assign bus.y         = set_q.y;
    assign bus.operation = set_q.operation;
    assign bus.valid     = valid_q;
    assign bus.new_set   = new_set_q;
    assign bus.stage     = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed plus randomized key-press bench for operand_entry with a small reference model.
// Latency: n/a; backpressure: n/a.
module tb_operand_entry;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_entry_if bus ();

    operand_entry #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: what the user has confirmed so far.
    int m_stage = 0;
    int m_x     = 0;
    int m_y     = 0;
    int m_op    = 0;
    int m_valid = 0;
    int m_sets  = 0;

    int   ns_cnt  = 0;
    int   ns_wide = 0;
    logic ns_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.new_set === 1'b1) ns_cnt++;
        if (bus.new_set === 1'b1 && ns_prev === 1'b1) ns_wide++;
        ns_prev = bus.new_set;
    end

    task automatic chk(input string where, input string tag,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s.%s got=%0h exp=%0h", where, tag, got, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk(where, "x",        bus.x,         m_x[3:0]);
        chk(where, "y",        bus.y,         m_y[3:0]);
        chk(where, "op",       bus.operation, m_op[1:0]);
        chk(where, "valid",    bus.valid,     m_valid[0]);
        chk(where, "stage",    bus.stage,     m_stage[1:0]);
        chk(where, "sets",     ns_cnt,        m_sets);
        chk(where, "pulsewid", ns_wide,       0);
    endtask

    task automatic m_reset();
        m_stage = 0; m_x = 0; m_y = 0; m_op = 0; m_valid = 0;
    endtask

    task automatic m_event(input bit ent, input bit can, input int s);
        if (can) begin
            m_reset();
        end else if (ent) begin
            if (m_stage == 0)      begin m_x = s; m_stage = 1; end
            else if (m_stage == 1) begin m_y = s; m_stage = 2; end
            else if (m_stage == 2) begin m_op = s % 4; m_valid = 1; m_sets++; m_stage = 3; end
            else                   begin m_valid = 0; m_stage = 0; end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the keys well past the debounce window, then release and settle.
    task automatic keys(input bit ent, input bit can, input logic [3:0] s);
        bus.sw       = s;
        bus.enter_n  = ~ent;
        bus.cancel_n = ~can;
        cycles(12);
        bus.enter_n  = 1'b1;
        bus.cancel_n = 1'b1;
        cycles(12);
        @(negedge clk);
        m_event(ent, can, int'(s));
    endtask

    task automatic glitch(input int n);
        bus.enter_n = 1'b0;
        cycles(n);
        bus.enter_n = 1'b1;
        cycles(12);
        @(negedge clk);
    endtask

    initial begin
        int r;
        logic [3:0] s;

        rst_n        = 1'b1;
        bus.sw       = 4'h0;
        bus.enter_n  = 1'b1;
        bus.cancel_n = 1'b1;

        #12 rst_n = 1'b0;
        #1 check_all("reset_async");
        cycles(3);
        rst_n = 1'b1;
        cycles(50);
        @(negedge clk);
        check_all("idle50");

        keys(1, 0, 4'b0101);
        check_all("x_cap");
        keys(1, 0, 4'b0011);
        check_all("y_cap");
        keys(1, 0, 4'b0011);
        check_all("full");

        keys(1, 0, 4'h0);
        check_all("restart");
        keys(1, 0, 4'h9);
        check_all("overwrite_x");
        keys(0, 1, 4'h0);
        check_all("cancel");
        keys(1, 0, 4'h9);
        keys(1, 1, 4'h7);
        check_all("both_keys");

        bus.sw = 4'h6;
        for (int i = 0; i < 10; i++) begin
            bus.enter_n = ~bus.enter_n;
            cycles(2);
        end
        keys(1, 0, 4'h6);
        check_all("bounce");
        glitch(3);
        check_all("glitch3");

        keys(1, 0, 4'h2);
        check_all("to_op");
        bus.sw      = 4'hB;
        bus.enter_n = 1'b0;
        cycles(2);
        #2 rst_n = 1'b0;
        m_reset();
        #1 check_all("reset_mid");
        cycles(2);
        rst_n = 1'b1;
        cycles(12);
        bus.enter_n = 1'b1;
        cycles(12);
        @(negedge clk);
        m_event(1, 0, 11);
        check_all("held_at_reset");

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            s = 4'($urandom_range(0, 15));
            if (r == 0)      keys(0, 1, s);
            else if (r == 1) keys(1, 1, s);
            else if (r == 2) glitch(int'($urandom_range(1, 3)));
            else             keys(1, 0, s);
            check_all("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
